// File: rtl/expmod_result_uart_tx.sv
// expmod_result_uart_tx
// Buffers exponent_modulus result words in a small FIFO and streams them to
// uart_transmit one byte at a time, MSB first, over the data_byte/trigger/busy
// handshake.
// Optional build macro RESULT_HEX_ASCII_EN: each word is sent as uppercase
// ASCII hex characters followed by CR LF instead of raw binary bytes.
module expmod_result_uart_tx #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [WIDTH-1:0]              word_in,
  input  logic                          valid_in,
  input  logic                          uart_busy_in,
  output logic [7:0]                    data_byte_out,
  output logic                          trigger_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          full_out,
  output logic                          overflow_out,
  output logic                          busy_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef RESULT_HEX_ASCII_EN
  localparam int NCHARS = WIDTH / 4 + 2;
`else
  localparam int NBYTES = WIDTH / 8;
  localparam int NCHARS = NBYTES;
`endif
  localparam int CNT_W = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NCHARS - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GUARD,
    ST_WAIT
  } state_t;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  state_t           state;
  logic [WIDTH-1:0] word_q;
  logic [CNT_W-1:0] byte_cnt;
  logic             guard_q;

  // Character that goes on the wire when the down-counter reads idx.
  // The counter starts at NCHARS-1, so the highest index is the first
  // character sent and idx 0 is the last.
  function automatic logic [7:0] char_at(input logic [WIDTH-1:0] w,
                                         input logic [CNT_W-1:0] idx);
`ifdef RESULT_HEX_ASCII_EN
    logic [3:0] nib;
    if (idx == CNT_W'(1)) return 8'h0D;
    if (idx == CNT_W'(0)) return 8'h0A;
    nib = 4'(w >> (4 * (int'(idx) - 2)));
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
`else
    return 8'(w >> (8 * int'(idx)));
`endif
  endfunction

  // Full is judged on the registered count, so a pop in the same cycle
  // does not make room for a push.
  assign full_out       = (count == DEPTH_CNT);
  assign fifo_count_out = count;
  assign push           = valid_in && !full_out;
  assign pop            = (state == ST_LOAD);
  assign busy_out       = (state != ST_IDLE) || (count != '0);

  // Word storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= word_in;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (valid_in && full_out) overflow_out <= 1'b1;
    end
  end

  // Serializer FSM: pop a word, then per character pulse trigger, sit out
  // the UART busy assertion latency, and wait for busy to fall.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state         <= ST_IDLE;
      word_q        <= '0;
      byte_cnt      <= '0;
      guard_q       <= 1'b0;
      data_byte_out <= 8'h00;
      trigger_out   <= 1'b0;
    end else begin
      trigger_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (count != '0) state <= ST_LOAD;
        end
        ST_LOAD: begin
          word_q        <= mem[rd_ptr];
          byte_cnt      <= LAST_IDX;
          data_byte_out <= char_at(mem[rd_ptr], LAST_IDX);
          trigger_out   <= 1'b1;
          state         <= ST_SEND;
        end
        ST_SEND: begin
          guard_q <= 1'b0;
          state   <= ST_GUARD;
        end
        ST_GUARD: begin
          guard_q <= 1'b1;
          if (guard_q) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!uart_busy_in) begin
            if (byte_cnt == '0) begin
              state <= ST_IDLE;
            end else begin
              byte_cnt      <= byte_cnt - 1'b1;
              data_byte_out <= char_at(word_q, byte_cnt - 1'b1);
              trigger_out   <= 1'b1;
              state         <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expmod_result_uart_tx.sv
// Bench for expmod_result_uart_tx: scoreboard of expected UART bytes,
// a simple uart_transmit busy model, and one task per scenario.
module tb_expmod_result_uart_tx;

  localparam int WIDTH      = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef RESULT_HEX_ASCII_EN
  localparam int NCHARS = WIDTH / 4 + 2;
  localparam logic [7:0] FIRST_1234 = 8'h31;
`else
  localparam int NCHARS = WIDTH / 8;
  localparam logic [7:0] FIRST_1234 = 8'h12;
`endif

  logic                        clk_in = 1'b0;
  logic                        rst_in = 1'b0;
  logic [WIDTH-1:0]            word_in = '0;
  logic                        valid_in = 1'b0;
  logic                        uart_busy_in = 1'b0;
  logic [7:0]                  data_byte_out;
  logic                        trigger_out;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_out;
  logic                        full_out;
  logic                        overflow_out;
  logic                        busy_out;

  expmod_result_uart_tx #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .word_in        (word_in),
    .valid_in       (valid_in),
    .uart_busy_in   (uart_busy_in),
    .data_byte_out  (data_byte_out),
    .trigger_out    (trigger_out),
    .fifo_count_out (fifo_count_out),
    .full_out       (full_out),
    .overflow_out   (overflow_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         trig_times[$];

  // uart model state
  bit model_on  = 1'b0;
  bit pend      = 1'b0;
  int busy_len  = 20;
  int busy_left = 0;

  // monitor state
  bit         rst_q     = 1'b0;
  bit         prev_trig = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk_in) begin
    cyc   <= cyc + 1;
    rst_q <= rst_in;
  end

  // uart_transmit stand-in: busy rises one cycle after a trigger, holds busy_len cycles
  always @(negedge clk_in) begin
    if (model_on) begin
      if (pend) begin
        uart_busy_in = 1'b1;
        busy_left    = busy_len;
        pend         = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) uart_busy_in = 1'b0;
      end
      if (trigger_out) pend = 1'b1;
    end
  end

  // Scoreboard monitor: every trigger must match the next expected byte
  always @(negedge clk_in) begin
    logic [7:0] e;
    if (rst_q) begin
      if (trigger_out) begin
        trig_times.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_trigger got=%h want=none", data_byte_out);
        end else begin
          e = exp_q.pop_front();
          if (data_byte_out !== e) begin
            bad++;
            $display("FAIL byte got=%h want=%h", data_byte_out, e);
          end
        end
        total++;
        if (prev_trig !== 1'b0) begin
          bad++;
          $display("FAIL trigger_width got=2+ cycles want=1");
        end
      end else begin
        total++;
        if (data_byte_out !== prev_data) begin
          bad++;
          $display("FAIL data_held got=%h want=%h", data_byte_out, prev_data);
        end
      end
    end
    prev_trig = trigger_out;
    prev_data = data_byte_out;
  end

`ifdef RESULT_HEX_ASCII_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[int'(n)];
  endfunction
`endif

  task automatic expect_word(input logic [WIDTH-1:0] w);
`ifdef RESULT_HEX_ASCII_EN
    for (int i = WIDTH / 4 - 1; i >= 0; i--) exp_q.push_back(hex_char(w[i*4 +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    for (int i = WIDTH / 8 - 1; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
`endif
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    @(negedge clk_in);
    valid_in = 1'b1;
    word_in  = w;
    expect_word(w);
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_in);
      if (busy_out === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic model_mode(input bit on, input int len);
    pend         = 1'b0;
    busy_left    = 0;
    busy_len     = len;
    uart_busy_in = 1'b0;
    model_on     = on;
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    total++; if (data_byte_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_byte_out); end
    total++; if (trigger_out !== 1'b0) begin bad++; $display("FAIL reset_trigger got=%b want=0", trigger_out); end
    total++; if (fifo_count_out !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count_out); end
    total++; if (full_out !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full_out); end
    total++; if (overflow_out !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow_out); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_out); end
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_single_word;
    bit ok;
    int n0;
    model_mode(1'b1, 20);
    n0 = trig_times.size();
    push_word(16'h1234);
    total++; if (fifo_count_out !== 3'd1) begin bad++; $display("FAIL lat_count got=%0d want=1", fifo_count_out); end
    total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL lat_busy got=%b want=1", busy_out); end
    total++; if (trigger_out !== 1'b0) begin bad++; $display("FAIL lat_n1 got=%b want=0", trigger_out); end
    @(negedge clk_in);
    total++; if (trigger_out !== 1'b0) begin bad++; $display("FAIL lat_n2 got=%b want=0", trigger_out); end
    @(negedge clk_in);
    total++; if (trigger_out !== 1'b1 || data_byte_out !== FIRST_1234) begin
      bad++; $display("FAIL lat_n3 got=%b/%h want=1/%h", trigger_out, data_byte_out, FIRST_1234);
    end
    wait_idle(1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_idle got=busy want=idle"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_left got=%0d want=0", exp_q.size()); end
    total++; if (trig_times.size() - n0 != NCHARS) begin
      bad++; $display("FAIL single_ntrig got=%0d want=%0d", trig_times.size() - n0, NCHARS);
    end
  endtask

  task automatic test_hex_word;
    bit ok;
    int n0;
    model_mode(1'b1, 5);
    n0 = trig_times.size();
    push_word(16'h0AF3);
    wait_idle(1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL hex_idle got=busy want=idle"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL hex_left got=%0d want=0", exp_q.size()); end
    total++; if (trig_times.size() - n0 != NCHARS) begin
      bad++; $display("FAIL hex_ntrig got=%0d want=%0d", trig_times.size() - n0, NCHARS);
    end
  endtask

  task automatic test_fifo_full;
    bit ok;
    model_mode(1'b0, 4);
    uart_busy_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_in);
      valid_in = 1'b1;
      word_in  = WIDTH'(i);
      expect_word(WIDTH'(i));
    end
    @(negedge clk_in);
    valid_in = 1'b0;
    total++; if (fifo_count_out !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", fifo_count_out); end
    total++; if (full_out !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", full_out); end
    total++; if (overflow_out !== 1'b0) begin bad++; $display("FAIL full_no_ovf got=%b want=0", overflow_out); end
    valid_in = 1'b1;
    word_in  = 16'h0006;
    @(negedge clk_in);
    valid_in = 1'b0;
    total++; if (overflow_out !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow_out); end
    total++; if (fifo_count_out !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", fifo_count_out); end
    model_mode(1'b1, 4);
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_idle got=busy want=idle"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drain_left got=%0d want=0", exp_q.size()); end
    total++; if (overflow_out !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow_out); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    model_mode(1'b1, 20);
    @(negedge clk_in);
    valid_in = 1'b1; word_in = 16'hBEEF; expect_word(16'hBEEF);
    @(negedge clk_in);
    word_in = 16'hCAFE; expect_word(16'hCAFE);
    @(negedge clk_in);
    valid_in = 1'b0;
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_idle got=busy want=idle"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_no_busy_spacing;
    bit ok;
    int s;
    int d;
    int want;
    model_mode(1'b0, 0);
    s = trig_times.size();
    @(negedge clk_in);
    valid_in = 1'b1; word_in = 16'hBEEF; expect_word(16'hBEEF);
    @(negedge clk_in);
    word_in = 16'hCAFE; expect_word(16'hCAFE);
    @(negedge clk_in);
    valid_in = 1'b0;
    wait_idle(1000, ok);
    total++; if (!ok || trig_times.size() != s + 2 * NCHARS) begin
      bad++; $display("FAIL space_ntrig got=%0d want=%0d", trig_times.size() - s, 2 * NCHARS);
    end else begin
      for (int i = 1; i < 2 * NCHARS; i++) begin
        d    = trig_times[s+i] - trig_times[s+i-1];
        want = (i == NCHARS) ? 6 : 4;
        total++;
        if (d != want) begin bad++; $display("FAIL spacing idx=%0d got=%0d want=%0d", i, d, want); end
      end
    end
  endtask

  task automatic test_busy_glitch;
    bit ok;
    bit found;
    model_mode(1'b0, 0);
    push_word(16'h1234);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (trigger_out === 1'b1) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL glitch_first got=none want=trigger"); end
    repeat (2) @(negedge clk_in);
    uart_busy_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      total++;
      if (trigger_out !== 1'b0) begin bad++; $display("FAIL glitch_hold cyc=%0d got=%b want=0", i, trigger_out); end
    end
    uart_busy_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      if (trigger_out === 1'b1) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL glitch_resume got=none want=trigger"); end
    wait_idle(1000, ok);
    total++; if (!ok || exp_q.size() != 0) begin
      bad++; $display("FAIL glitch_drain got=%0d left want=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_word;
    bit found;
    int n0;
    model_mode(1'b1, 20);
    n0 = trig_times.size();
    @(negedge clk_in);
    valid_in = 1'b1;
    word_in  = 16'h1234;
    exp_q.push_back(FIRST_1234);
    @(negedge clk_in);
    valid_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (trigger_out === 1'b1) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL mid_first got=none want=trigger"); end
    repeat (5) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    total++; if (trigger_out !== 1'b0) begin bad++; $display("FAIL mid_trigger got=%b want=0", trigger_out); end
    total++; if (fifo_count_out !== '0) begin bad++; $display("FAIL mid_count got=%0d want=0", fifo_count_out); end
    total++; if (overflow_out !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b want=0", overflow_out); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy_out); end
    total++; if (data_byte_out !== 8'h00) begin bad++; $display("FAIL mid_data got=%h want=00", data_byte_out); end
    rst_in = 1'b1;
    repeat (60) @(negedge clk_in);
    total++; if (trig_times.size() - n0 != 1) begin
      bad++; $display("FAIL mid_ntrig got=%0d want=1", trig_times.size() - n0);
    end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL mid_after_busy got=%b want=0", busy_out); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_hex_word();
    test_fifo_full();
    test_back_to_back();
    test_no_busy_spacing();
    test_busy_glitch();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
